me_scan_ctrl: RTL and testbench

ME_SCAN_CTRL -- requirements
Module: me_scan_ctrl

---
 rtl/me_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_me_scan_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/me_scan_ctrl.sv
// Address and enable sequencer for a full-search block-matching PE array.
// Loads one macroblock, then walks every candidate offset in serpentine column order.
module me_scan_ctrl #(
    parameter int MACRO_DIM  = 16,
    parameter int SEARCH_DIM = 48
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic                                        stall,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        en_cpr,
    output logic                                        en_spr,
    output logic [1:0]                                  sel,
    output logic [$clog2(MACRO_DIM)-1:0]                cpr_row,
    output logic [$clog2(SEARCH_DIM)-1:0]               spr_row,
    output logic [$clog2(SEARCH_DIM)-1:0]               spr_col,
    output logic                                        ad_valid,
    output logic [$clog2(SEARCH_DIM-MACRO_DIM+1)-1:0]   mv_x,
    output logic [$clog2(SEARCH_DIM-MACRO_DIM+1)-1:0]   mv_y
);

    localparam int N  = SEARCH_DIM - MACRO_DIM + 1;
    localparam int CW = $clog2(MACRO_DIM);
    localparam int SW = $clog2(SEARCH_DIM);
    localparam int MW = $clog2(N);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_SCAN = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] SEL_DOWN  = 2'd0;
    localparam logic [1:0] SEL_UP    = 2'd1;
    localparam logic [1:0] SEL_LEFT  = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] row;
    logic [MW-1:0] cx;
    logic [MW-1:0] cy;
    logic          col_end;
    logic          last_cand;

    // Even columns walk downward, odd columns upward; the turn happens at the far edge.
    assign col_end   = cx[0] ? (cy == '0) : (cy == MW'(N - 1));
    assign last_cand = col_end && (cx == MW'(N - 1));

    assign mv_x = cx;
    assign mv_y = cy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            row   <= '0;
            cx    <= '0;
            cy    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_LOAD;
                        row   <= '0;
                        cx    <= '0;
                        cy    <= '0;
                    end
                end
                S_LOAD: begin
                    if (!stall) begin
                        if (row == CW'(MACRO_DIM - 1)) begin
                            state <= S_SCAN;
                            row   <= '0;
                            cx    <= '0;
                            cy    <= '0;
                        end else begin
                            row <= row + 1'b1;
                        end
                    end
                end
                S_SCAN: begin
                    if (!stall) begin
                        if (last_cand) begin
                            state <= S_DONE;
                            cx    <= '0;
                            cy    <= '0;
                        end else if (col_end) begin
                            cx <= cx + 1'b1;
                        end else if (cx[0]) begin
                            cy <= cy - 1'b1;
                        end else begin
                            cy <= cy + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cx    <= '0;
                    cy    <= '0;
                end
            endcase
        end
    end

    // Addresses decode from registered counters only; stall merely gates the enables.
    always_comb begin
        busy     = (state != S_IDLE);
        done     = (state == S_DONE);
        en_cpr   = 1'b0;
        en_spr   = 1'b0;
        ad_valid = 1'b0;
        sel      = SEL_DOWN;
        cpr_row  = '0;
        spr_row  = '0;
        spr_col  = '0;
        case (state)
            S_LOAD: begin
                en_cpr  = !stall;
                en_spr  = !stall;
                cpr_row = row;
                spr_row = SW'(row);
            end
            S_SCAN: begin
                ad_valid = !stall;
                if (!last_cand) begin
                    en_spr = !stall;
                    if (col_end) begin
                        sel     = SEL_LEFT;
                        spr_col = SW'(int'(cx) + MACRO_DIM);
                        spr_row = SW'(cy);
                    end else if (cx[0]) begin
                        sel     = SEL_UP;
                        spr_row = SW'(int'(cy) - 1);
                    end else begin
                        sel     = SEL_DOWN;
                        spr_row = SW'(int'(cy) + MACRO_DIM);
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_me_scan_ctrl.sv
// Bench for me_scan_ctrl: per-cycle comparison against a candidate-list reference,
// plus a short run of a reduced-size instance.
module tb_me_scan_ctrl;

    localparam int M  = 16;
    localparam int S  = 48;
    localparam int N  = S - M + 1;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       en_cpr;
        logic       en_spr;
        logic       ad_valid;
        logic [1:0] sel;
        logic [3:0] cpr_row;
        logic [5:0] spr_row;
        logic [5:0] spr_col;
        logic [5:0] mv_x;
        logic [5:0] mv_y;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       stall = 1'b0;
    logic       busy, done, en_cpr, en_spr, ad_valid;
    logic [1:0] sel;
    logic [3:0] cpr_row;
    logic [5:0] spr_row, spr_col, mv_x, mv_y;

    logic       start_s = 1'b0;
    logic       busy_s, done_s, en_cpr_s, en_spr_s, ad_valid_s;
    logic [1:0] sel_s, cpr_row_s;
    logic [2:0] spr_row_s, spr_col_s, mv_x_s, mv_y_s;

    int n_tests = 0;
    int n_fail  = 0;
    rec_t plan[$];

    always #5 clk = ~clk;

    me_scan_ctrl #(.MACRO_DIM(M), .SEARCH_DIM(S)) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .busy(busy), .done(done), .en_cpr(en_cpr), .en_spr(en_spr),
        .sel(sel), .cpr_row(cpr_row), .spr_row(spr_row), .spr_col(spr_col),
        .ad_valid(ad_valid), .mv_x(mv_x), .mv_y(mv_y)
    );

    me_scan_ctrl #(.MACRO_DIM(4), .SEARCH_DIM(8)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .stall(1'b0),
        .busy(busy_s), .done(done_s), .en_cpr(en_cpr_s), .en_spr(en_spr_s),
        .sel(sel_s), .cpr_row(cpr_row_s), .spr_row(spr_row_s), .spr_col(spr_col_s),
        .ad_valid(ad_valid_s), .mv_x(mv_x_s), .mv_y(mv_y_s)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic rec_t observed();
        rec_t r;
        r.busy = busy; r.done = done; r.en_cpr = en_cpr; r.en_spr = en_spr;
        r.ad_valid = ad_valid; r.sel = sel; r.cpr_row = cpr_row;
        r.spr_row = spr_row; r.spr_col = spr_col; r.mv_x = mv_x; r.mv_y = mv_y;
        return r;
    endfunction

    // Reference: list of candidates in visiting order; the shift issued at each
    // candidate is whatever moves the window to the next entry of that list.
    task automatic build_plan();
        int xs[$];
        int ys[$];
        rec_t r;
        plan.delete();
        for (int k = 0; k < M; k++) begin
            r = '0; r.busy = 1; r.en_cpr = 1; r.en_spr = 1;
            r.cpr_row = 4'(k); r.spr_row = 6'(k);
            plan.push_back(r);
        end
        for (int x = 0; x < N; x++)
            for (int j = 0; j < N; j++) begin
                xs.push_back(x);
                ys.push_back((x % 2 == 0) ? j : N - 1 - j);
            end
        for (int i = 0; i < xs.size(); i++) begin
            r = '0; r.busy = 1; r.ad_valid = 1;
            r.mv_x = 6'(xs[i]); r.mv_y = 6'(ys[i]);
            if (i + 1 < xs.size()) begin
                r.en_spr = 1;
                if (xs[i+1] == xs[i] + 1) begin
                    r.sel = 2; r.spr_col = 6'(xs[i] + M); r.spr_row = 6'(ys[i]);
                end else if (ys[i+1] == ys[i] + 1) begin
                    r.sel = 0; r.spr_row = 6'(ys[i] + M);
                end else begin
                    r.sel = 1; r.spr_row = 6'(ys[i] - 1);
                end
            end
            plan.push_back(r);
        end
        r = '0; r.busy = 1; r.done = 1;
        plan.push_back(r);
    endtask

    function automatic int find_cand(input int x, input int y);
        for (int i = 0; i < plan.size(); i++)
            if (plan[i].ad_valid && plan[i].mv_x == 6'(x) && plan[i].mv_y == 6'(y)) return i;
        return -1;
    endfunction

    // mode 0: spurious starts, 1: five stalls at (7,10), 2: random stalls.
    task automatic run_search(input string name, input int mode, input int abort_idx);
        int   cycle = 0;
        int   idx = 0;
        int   nst = 0;
        int   sidx;
        logic s;
        rec_t e;
        sidx = find_cand(7, 10);
        @(negedge clk);
        start = 1; stall = 0;
        #1 check({name, "_idle_pre"}, 64'(observed().busy), 64'(0));
        while (idx < plan.size()) begin
            @(negedge clk);
            cycle++;
            s = 1'b0;
            if (mode == 1 && idx == sidx && nst < 5) s = 1'b1;
            if (mode == 2 && $urandom_range(0, 9) == 0) s = 1'b1;
            stall = s;
            start = (mode == 0) ? (plan[idx].done || $urandom_range(0, 7) == 0) : 1'b0;
            #1;
            e = plan[idx];
            if (e.done) begin
                check({name, "_done_cycle"}, 64'(cycle), 64'(M + N * N + 1 + nst));
            end else if (s) begin
                e.en_cpr = 0; e.en_spr = 0; e.ad_valid = 0;
                nst++;
            end
            check({name, "_cyc"}, 64'(observed()), 64'(e));
            if (idx == abort_idx) begin
                rst = 1;
                #1 check({name, "_rst_async"}, 64'(observed()), 64'(0));
                @(negedge clk);
                start = 0; stall = 0; rst = 0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    #1 check({name, "_after_rst"}, 64'(observed()), 64'(0));
                end
                return;
            end
            if (e.done || !s) idx++;
        end
        @(negedge clk);
        start = 0; stall = 0;
        #1 check({name, "_idle_post"}, 64'(observed()), 64'(0));
    endtask

    task automatic run_small();
        int cycle = 0;
        int done_cyc = -1;
        int nadv = 0;
        logic [5:0] last_mv = '0;
        @(negedge clk);
        start_s = 1;
        @(negedge clk);
        start_s = 0;
        cycle = 1;
        #1;
        while (cycle < 100) begin
            if (ad_valid_s) begin nadv++; last_mv = {mv_x_s, mv_y_s}; end
            if (done_s) begin done_cyc = cycle; break; end
            @(negedge clk);
            cycle++;
            #1;
        end
        check("small_done_cycle", 64'(done_cyc), 64'(30));
        check("small_ad_valid_count", 64'(nadv), 64'(25));
        check("small_last_mv", 64'(last_mv), 64'({3'd4, 3'd4}));
        @(negedge clk);
        #1 check("small_busy_post", 64'(busy_s), 64'(0));
    endtask

    initial begin
        build_plan();
        @(negedge clk);
        #1 check("reset_state", 64'(observed()), 64'(0));
        rst = 0;
        @(negedge clk);
        #1 check("idle_state", 64'(observed()), 64'(0));

        run_search("plain", 0, -1);
        run_search("repeat", 0, -1);
        run_search("stall5", 1, -1);
        run_search("rstall", 2, -1);
        run_search("abort", 2, find_cand(3, 5));
        run_search("fresh", 0, -1);
        run_small();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
